mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 33 +++
 rtl/mem_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the instruction-fetch port, the load/store byte port and the
// single-port RAM port of mem_ctrl.
//   slave  : the controller side (mem_ctrl)
//   master : the side that drives requests and models the RAM (pipeline / bench)
// Signal suffixes are relative to the controller: _i are inputs to mem_ctrl, _o are outputs.
interface mem_ctrl_if;
    // Instruction fetch
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_inst_o;
    logic        if_done_o;
    // Load/store byte access
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_data_i;
    logic [7:0]  mem_data_o;
    // Single-port RAM, one-cycle read latency
    logic [31:0] ram_addr_o;
    logic        ram_we_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_data_i, ram_din_i,
        output if_inst_o, if_done_o, mem_data_o, ram_addr_o, ram_we_o, ram_dout_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_data_i, ram_din_i,
        input  if_inst_o, if_done_o, mem_data_o, ram_addr_o, ram_we_o, ram_dout_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide single-port RAM between a 32-bit instruction fetch
// (assembled from four byte reads, little-endian) and a byte-serial load/store stage.
// The load/store stage always has priority and may abort a fetch in progress.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_ctrl_if.slave: fetch port (if_*), load/store port (mem_*), RAM port (ram_*)
module mem_ctrl (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StDone, StMemg} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] fa_q, fa_d;
    logic [7:0]  b0_q, b0_d;
    logic [7:0]  b1_q, b1_d;
    logic [7:0]  b2_q, b2_d;
    logic [31:0] inst_q, inst_d;
    logic        done_q, done_d;
    logic [31:0] fetch_off;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fa_d    = fa_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        inst_d  = inst_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.mem_req_i) begin
                    state_d = StMemg;
                end else if (bus.if_req_i) begin
                    state_d = StFetch;
                    cnt_d   = 4'd0;
                    fa_d    = bus.if_addr_i;
                end
            end
            StFetch: begin
                if (bus.mem_req_i) begin
                    // Abort: partial bytes are dead, a later fetch restarts at cnt 0.
                    state_d = StMemg;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    // RAM data lags the address by one cycle, so byte cnt-1 arrives now.
                    case (cnt_q)
                        4'd1: b0_d = bus.ram_din_i;
                        4'd2: b1_d = bus.ram_din_i;
                        4'd3: b2_d = bus.ram_din_i;
                        4'd4: begin
                            inst_d  = {bus.ram_din_i, b2_q, b1_q, b0_q};
                            state_d = StDone;
                            done_d  = 1'b1;
                            cnt_d   = 4'd0;
                        end
                        default: ;
                    endcase
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StMemg: begin
                if (!bus.mem_req_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            fa_q    <= 32'd0;
            b0_q    <= 8'd0;
            b1_q    <= 8'd0;
            b2_q    <= 8'd0;
            inst_q  <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fa_q    <= fa_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            inst_q  <= inst_d;
            done_q  <= done_d;
        end
    end

    // cnt=4 only waits for the last byte's data, so the address stays on fa+3.
    assign fetch_off = (cnt_q == 4'd4) ? 32'd3 : {28'd0, cnt_q};

    // RAM port. Gated by rst so nothing reaches the RAM while reset is held.
    always_comb begin
        bus.ram_addr_o = 32'd0;
        bus.ram_we_o   = 1'b0;
        bus.ram_dout_o = 8'h00;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    bus.ram_addr_o = fa_q + fetch_off;
                end
                StMemg: begin
                    bus.ram_addr_o = bus.mem_addr_i;
                    bus.ram_we_o   = bus.mem_we_i;
                    bus.ram_dout_o = bus.mem_data_i;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_data_o = bus.ram_din_i;
    assign bus.if_inst_o  = inst_q;
    assign bus.if_done_o  = done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  ram [0:1023];

    function automatic logic [7:0] init_byte(input logic [9:0] idx);
        case (idx)
            10'h100: return 8'h13;
            10'h101: return 8'h05;
            10'h102: return 8'h50;
            10'h103: return 8'h00;
            10'h104: return 8'h11;
            10'h105: return 8'h22;
            10'h106: return 8'h33;
            10'h107: return 8'h44;
            10'h3FE: return 8'hAA;
            10'h3FF: return 8'hBB;
            10'h000: return 8'hCC;
            10'h001: return 8'hDD;
            default: return 8'h00;
        endcase
    endfunction

    // RAM model: low 10 address bits, synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_byte(10'(i));
        end else if (bus.ram_we_o) begin
            ram[bus.ram_addr_o[9:0]] <= bus.ram_dout_o;
        end
        bus.ram_din_i <= ram[bus.ram_addr_o[9:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ram_addr"}, bus.ram_addr_o, 32'd0);
        chk({tag, "_ram_we"}, {31'd0, bus.ram_we_o}, 32'd0);
        chk({tag, "_ram_dout"}, {24'd0, bus.ram_dout_o}, 32'd0);
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.if_done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    // Scoreboard monitor: every if_done_o pulse consumes one expected instruction.
    always @(negedge clk) begin
        if (bus.if_done_o === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_done: got pulse with inst %h, expected no pulse",
                         bus.if_inst_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.if_inst_o !== e) begin
                    n_err++;
                    $display("FAIL sb_inst: got %h, expected %h", bus.if_inst_o, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e_addr;
        logic [7:0]  ld_bytes [4];
        logic [31:0] wrap_addr [4];
        ld_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44};
        wrap_addr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = 32'd0;
        // A pending write request while reset is held must not reach the RAM.
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b1;
        bus.mem_addr_i = 32'h55;
        bus.mem_data_i = 8'h77;
        rst = 1'b1;

        // Reset
        next_cyc();
        next_cyc();
        smp();
        chk_quiet("rst");
        chk("rst_if_done", {31'd0, bus.if_done_o}, 32'd0);
        chk("rst_if_inst", bus.if_inst_o, 32'd0);
        next_cyc();
        bus.mem_req_i  = 1'b0;
        bus.mem_we_i   = 1'b0;
        bus.mem_addr_i = 32'd0;
        bus.mem_data_i = 8'h00;
        rst = 1'b0;
        smp();
        chk_quiet("idle");

        // Basic fetch from 0x100, latency profile
        next_cyc();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        exp_q.push_back(32'h0050_0513);
        for (int c = 1; c <= 6; c++) begin
            next_cyc();
            if (c == 1) bus.if_req_i = 1'b0;
            smp();
            if (c <= 5) begin
                e_addr = 32'h100 + ((c == 5) ? 32'd3 : 32'(c - 1));
                chk("f_addr", bus.ram_addr_o, e_addr);
            end
            chk("f_we", {31'd0, bus.ram_we_o}, 32'd0);
            chk("f_done", {31'd0, bus.if_done_o}, (c == 6) ? 32'd1 : 32'd0);
        end

        // Simultaneous requests: store wins, fetch follows after release
        next_cyc();
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b1;
        bus.mem_addr_i = 32'h200;
        bus.mem_data_i = 8'hAB;
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h100;
        exp_q.push_back(32'h0050_0513);
        for (int c = 0; c < 3; c++) begin
            next_cyc();
            smp();
            chk("st_we", {31'd0, bus.ram_we_o}, 32'd1);
            chk("st_addr", bus.ram_addr_o, 32'h200);
            chk("st_dout", {24'd0, bus.ram_dout_o}, 32'hAB);
        end
        next_cyc();
        bus.mem_req_i  = 1'b0;
        bus.mem_we_i   = 1'b0;
        bus.mem_addr_i = 32'd0;
        bus.mem_data_i = 8'h00;
        next_cyc();
        smp();
        chk_quiet("st_idle");
        next_cyc();
        bus.if_req_i = 1'b0;
        smp();
        chk("st_fetch_addr", bus.ram_addr_o, 32'h100);
        wait_done("st");
        chk("st_ram_200", {24'd0, ram[10'h200]}, 32'hAB);

        // Byte-serial load from 0x104..0x107
        next_cyc();
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_addr_i = 32'h104;
        next_cyc();
        smp();
        chk("ld_addr", bus.ram_addr_o, 32'h104);
        chk("ld_we", {31'd0, bus.ram_we_o}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            next_cyc();
            if (k < 4) bus.mem_addr_i = 32'h104 + 32'(k);
            else bus.mem_req_i = 1'b0;
            smp();
            chk("ld_data", {24'd0, bus.mem_data_o}, {24'd0, ld_bytes[k-1]});
            chk("ld_we", {31'd0, bus.ram_we_o}, 32'd0);
        end
        bus.mem_addr_i = 32'd0;

        // Wrapping fetch; if_addr_i changes mid-fetch are ignored
        next_cyc();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'hFFFF_FFFE;
        exp_q.push_back(32'hDDCC_BBAA);
        for (int c = 1; c <= 4; c++) begin
            next_cyc();
            if (c == 1) begin
                bus.if_req_i  = 1'b0;
                bus.if_addr_i = 32'h5555_0000;
            end
            smp();
            chk("wrap_addr", bus.ram_addr_o, wrap_addr[c-1]);
        end
        wait_done("wrap");

        // Fetch aborted at cnt=2 by a load, then restarted from byte 0
        next_cyc();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        exp_q.push_back(32'h0050_0513);
        next_cyc();
        next_cyc();
        next_cyc();
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_addr_i = 32'h300;
        smp();
        chk("ab_cnt2_addr", bus.ram_addr_o, 32'h102);
        next_cyc();
        smp();
        chk("ab_memg_addr", bus.ram_addr_o, 32'h300);
        chk("ab_memg_done", {31'd0, bus.if_done_o}, 32'd0);
        chk("ab_memg_inst", bus.if_inst_o, 32'hDDCC_BBAA);
        next_cyc();
        bus.mem_req_i = 1'b0;
        smp();
        chk("ab_rel_inst", bus.if_inst_o, 32'hDDCC_BBAA);
        next_cyc();
        smp();
        chk_quiet("ab_idle");
        next_cyc();
        bus.if_req_i = 1'b0;
        smp();
        chk("ab_restart_addr", bus.ram_addr_o, 32'h100);
        wait_done("ab");

        // Reset during fetch at cnt=3
        next_cyc();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h104;
        next_cyc();
        bus.if_req_i = 1'b0;
        next_cyc();
        next_cyc();
        next_cyc();
        rst = 1'b1;
        smp();
        chk_quiet("rf_rst");
        next_cyc();
        rst = 1'b0;
        smp();
        chk_quiet("rf_after");
        chk("rf_done", {31'd0, bus.if_done_o}, 32'd0);
        chk("rf_inst", bus.if_inst_o, 32'd0);
        for (int i = 0; i < 8; i++) next_cyc();
        smp();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
